// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on
// device clock falls, ACK check and bus-idle wait, with a per-phase timeout.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE
   } state_t;

   localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] TIMEOUT_LIM  = 20'(TIMEOUT_CYCLES);

   state_t      state, state_next;
   logic [1:0]  clk_sync, dat_sync;
   logic        sync_clk, sync_dat, sync_clk_d;
   logic        fall, watch, fall_act, timeout, accept;
   logic [9:0]  shift;
   logic        cur_bit;
   logic [3:0]  bitcnt;
   logic [19:0] cnt;
   logic        err;

   assign sync_clk = clk_sync[1];
   assign sync_dat = dat_sync[1];
   assign fall     = sync_clk_d & ~sync_clk;
   // Our own clock inhibit also produces a fall; only device phases react to it.
   assign watch    = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
   assign fall_act = fall & watch;
   assign timeout  = watch & ~fall & (cnt == TIMEOUT_LIM);
   assign accept   = tx_valid & (state == S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync   <= '1;
         dat_sync   <= '1;
         sync_clk_d <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk_in};
         dat_sync   <= {dat_sync[0], ps2_dat_in};
         sync_clk_d <= sync_clk;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      case (state)
         S_IDLE: begin
            if (tx_valid) state_next = S_INHIBIT;
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (cnt == INHIBIT_LAST) state_next = S_REQ;
         end
         S_REQ: begin
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = 1'b1;
            state_next = S_SEND;
         end
         S_SEND: begin
            if (timeout) begin
               state_next = S_DONE;
            end else begin
               ps2_dat_oe = ~cur_bit;
               if (fall && bitcnt == 4'd9) state_next = S_ACK;
            end
         end
         S_ACK: begin
            if (timeout)   state_next = S_DONE;
            else if (fall) state_next = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (timeout || (sync_clk && sync_dat)) state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift   <= '0;
         cur_bit <= 1'b1;
         bitcnt  <= '0;
         cnt     <= '0;
         err     <= 1'b0;
      end else begin
         if (state == S_IDLE || state_next != state || fall_act) cnt <= '0;
         else                                                    cnt <= cnt + 20'd1;

         if (accept) begin
            shift   <= {1'b1, ~^tx_data, tx_data};
            cur_bit <= 1'b0;
            bitcnt  <= '0;
            err     <= 1'b0;
         end

         // Shift register feeds cur_bit so the start bit stays up until the first fall.
         if (state == S_SEND && fall) begin
            cur_bit <= shift[0];
            shift   <= {1'b1, shift[9:1]};
            bitcnt  <= bitcnt + 4'd1;
         end

         if (state == S_ACK && fall && sync_dat) err <= 1'b1;
         if (timeout)                            err <= 1'b1;
      end
   end

   assign tx_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign tx_done  = (state == S_DONE);
   assign tx_err   = (state == S_DONE) & err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus model plus a device-side
// clocking model that captures the frame and answers ACK/NACK or stalls.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_ready, tx_done, tx_err, busy;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       clk_pin, dat_pin;

   assign clk_pin = ~(ps2_clk_oe | dev_clk_low);
   assign dat_pin = ~(ps2_dat_oe | dev_dat_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(2000)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .busy       (busy),
      .ps2_clk_in (clk_pin),
      .ps2_dat_in (dat_pin),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   int n_vec = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int         cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         inh_run = 0;
   int         last_inh = 0;
   int         last_fall_cyc = 0;
   logic       last_err = 1'b0;
   logic [1:0] done_oe = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         last_err <= tx_err;
         done_oe  <= {ps2_clk_oe, ps2_dat_oe};
      end
      if (ps2_clk_oe && !ps2_dat_oe) begin
         inh_run <= inh_run + 1;
      end else begin
         if (ps2_clk_oe && ps2_dat_oe) last_inh <= inh_run;
         inh_run <= 0;
      end
   end

   task automatic start_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Device side: waits for request-to-send, gives nclk data clocks (40 clk
   // period, sampling at the rising edge), then an 11th ACK clock if nclk > 10.
   task automatic dev_xfer(input int nclk, input bit ack, output logic [10:0] bits, output bit ok);
      bits = '1;
      ok   = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (clk_pin === 1'b1 && dat_pin === 1'b0 && busy === 1'b1) ok = 1'b1;
      end
      if (!ok) return;
      bits[0] = dat_pin;
      repeat (10) @(negedge clk);
      for (int k = 1; k <= nclk && k <= 10; k++) begin
         dev_clk_low   = 1'b1;
         last_fall_cyc = cyc;
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         bits[k]     = dat_pin;
         repeat (20) @(negedge clk);
      end
      if (nclk > 10) begin
         if (ack) dev_dat_low = 1'b1;
         repeat (5) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
         dev_dat_low = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic wait_done(input int base, input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (done_cnt > base) seen = 1'b1;
      end
   endtask

   task automatic xfer(input string tag, input logic [7:0] d, input bit ack,
                       input logic [10:0] exp_bits, input bit exp_err);
      int         base;
      logic [10:0] bits;
      bit          ok, seen;
      base = done_cnt;
      start_tx(d);
      dev_xfer(11, ack, bits, ok);
      check({tag, "_req"}, ok, 1);
      check({tag, "_bits"}, bits, exp_bits);
      wait_done(base, 3000, seen);
      check({tag, "_done"}, seen, 1);
      repeat (3) @(negedge clk);
      check({tag, "_pulses"}, done_cnt - base, 1);
      check({tag, "_err"}, last_err, exp_err);
      check({tag, "_ready"}, tx_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          base, lat;
      logic [10:0] bits;
      bit          ok, seen;

      repeat (5) @(negedge clk);
      check("reset_outs", {tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // 0xED: six ones, odd parity bit 1
      xfer("ed", 8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0);

      xfer("x00", 8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
      check("x00_inhibit", last_inh, 10);
      xfer("x01", 8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0);
      check("x01_inhibit", last_inh, 10);

      xfer("nack", 8'hFF, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1);

      // 0xF4 stalls after bit 3: start,0,0,1,0 on the wire
      base = done_cnt;
      start_tx(8'hF4);
      dev_xfer(4, 1'b1, bits, ok);
      check("to_req", ok, 1);
      check("to_bits", bits[4:0], 5'b01000);
      for (int i = 0; i < 3000 && cyc < last_fall_cyc + 1900; i++) @(negedge clk);
      check("to_pre", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b101);
      check("to_pre_nodone", done_cnt - base, 0);
      wait_done(base, 300, seen);
      check("to_done", seen, 1);
      lat = done_cyc - last_fall_cyc;
      check("to_latency_window", (lat >= 2000 && lat <= 2006), 1);
      check("to_err", last_err, 1);
      check("to_done_oe", done_oe, 2'b00);

      // 0x1F: bit 5 is 0, so the data line is driven when reset hits
      base = done_cnt;
      start_tx(8'h1F);
      dev_xfer(6, 1'b1, bits, ok);
      check("rst_req", ok, 1);
      check("rst_bits", bits[6:0], 7'b0111110);
      check("rst_pre", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b101);
      @(negedge clk);
      #3 rst = 1'b0;
      #1 check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("rst_after_ready", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
      check("rst_no_done", done_cnt - base, 0);

      // valid held across a transfer with new data: not queued mid-frame
      base = done_cnt;
      @(negedge clk);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(negedge clk);
      check("hold_busy", busy, 1);
      tx_data = 8'h55;
      dev_xfer(11, 1'b1, bits, ok);
      check("hold_first_bits", bits, {1'b1, 1'b1, 8'h3C, 1'b0});
      wait_done(base, 3000, seen);
      check("hold_first_done", seen, 1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      tx_valid = 1'b0;
      check("hold_second_accept", seen, 1);
      dev_xfer(11, 1'b1, bits, ok);
      check("hold_second_bits", bits, {1'b1, 1'b1, 8'h55, 1'b0});
      wait_done(base + 1, 3000, seen);
      check("hold_second_done", seen, 1);
      repeat (20) @(negedge clk);
      check("hold_final", {done_cnt - base, 31'(busy)}, {32'd2, 31'd0});
      check("hold_err", last_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
